serializer: RTL and testbench

// - Parallel-to-serial converter; transmit-side counterpart of the team's deserializer.
// - Accepts one block of N_SAMPLES words over a single val/rdy handshake.
// - Emits the words one at a time on a BIT_WIDTH val/rdy stream toward a serial consumer.
//

---
 rtl/serializer_pkg.sv | 9 +
 rtl/serializer_ctrl.sv | 76 +++++++
 rtl/serializer.sv | 55 +++++
 tb/tb_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types for the serializer and its deserializer counterpart.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/serializer_ctrl.sv
// Serializer control: IDLE/SEND state machine and word counter.
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int COUNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recv_val,
  input  logic               send_rdy,
  output logic               recv_rdy,
  output logic               send_val,
  output logic               bank_we,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(N_SAMPLES - 1);

  state_e             state;
  state_e             state_next;
  logic [COUNT_W-1:0] count_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    bank_we    = 1'b0;

    unique case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          bank_we    = 1'b1;
          count_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        send_val = 1'b1;
        if (send_rdy) begin
          if (count == LAST) begin
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Handshake outputs stay low for the whole reset cycle, whatever the state.
    if (reset) begin
      recv_rdy = 1'b0;
      send_val = 1'b0;
      bank_we  = 1'b0;
    end
  end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter: one block in, N_SAMPLES words out, word 0 first.
module serializer
  import serializer_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg
);

  localparam int COUNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

  logic                 bank_we;
  logic [COUNT_W-1:0]   count;
  logic [BIT_WIDTH-1:0] bank [N_SAMPLES];

  serializer_ctrl #(
    .N_SAMPLES (N_SAMPLES),
    .COUNT_W   (COUNT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .bank_we  (bank_we),
    .count    (count)
  );

  // NOTE: the word bank has no reset; it is only read while send_val is high,
  // which always follows a capture, so its power-up contents are never seen.
  always_ff @(posedge clk) begin
    if (bank_we) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        bank[i] <= recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    send_msg = bank[0];
    for (int i = 1; i < N_SAMPLES; i++) begin
      if (count == COUNT_W'(i)) send_msg = bank[i];
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: queue-based reference model, N=8/W=32 and N=1/W=16.
module tb_serializer;

  localparam int W8 = 32;
  localparam int N8 = 8;
  localparam int W1 = 16;
  localparam int N1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset8 = 1'b1;
  logic               recv_val8 = 1'b0;
  logic               recv_rdy8;
  logic [N8*W8-1:0]   recv_msg8 = '0;
  logic               send_val8;
  logic               send_rdy8 = 1'b0;
  logic [W8-1:0]      send_msg8;

  logic               reset1 = 1'b1;
  logic               recv_val1 = 1'b0;
  logic               recv_rdy1;
  logic [N1*W1-1:0]   recv_msg1 = '0;
  logic               send_val1;
  logic               send_rdy1 = 1'b0;
  logic [W1-1:0]      send_msg1;

  serializer #(.BIT_WIDTH(W8), .N_SAMPLES(N8)) dut8 (
    .clk      (clk),
    .reset    (reset8),
    .recv_val (recv_val8),
    .recv_rdy (recv_rdy8),
    .recv_msg (recv_msg8),
    .send_val (send_val8),
    .send_rdy (send_rdy8),
    .send_msg (send_msg8)
  );

  serializer #(.BIT_WIDTH(W1), .N_SAMPLES(N1)) dut1 (
    .clk      (clk),
    .reset    (reset1),
    .recv_val (recv_val1),
    .recv_rdy (recv_rdy1),
    .recv_msg (recv_msg1),
    .send_val (send_val1),
    .send_rdy (send_rdy1),
    .send_msg (send_msg1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words still owed downstream. Empty means ready for a block.
  logic [W8-1:0] q8[$];
  logic [W1-1:0] q1[$];
  int beats1 = 0;
  int hs1    = 0;

  function automatic logic [N8*W8-1:0] rand_blk8();
    logic [N8*W8-1:0] b;
    for (int i = 0; i < N8; i++) b[i*W8 +: W8] = $urandom;
    return b;
  endfunction

  // One clock of dut8: drive at negedge, compare against the model, advance the model.
  task automatic cycle8(input logic rst, input logic rv, input logic [N8*W8-1:0] msg,
                        input logic sr);
    logic exp_rdy;
    logic exp_val;
    reset8    = rst;
    recv_val8 = rv;
    recv_msg8 = msg;
    send_rdy8 = sr;
    #1;
    exp_rdy = !rst && (q8.size() == 0);
    exp_val = !rst && (q8.size() != 0);
    n_tests++;
    if (recv_rdy8 !== exp_rdy) begin
      n_fail++;
      $display("FAIL recv_rdy8 @%0t: got %b expected %b", $time, recv_rdy8, exp_rdy);
    end
    n_tests++;
    if (send_val8 !== exp_val) begin
      n_fail++;
      $display("FAIL send_val8 @%0t: got %b expected %b", $time, send_val8, exp_val);
    end
    if (exp_val) begin
      n_tests++;
      if (send_msg8 !== q8[0]) begin
        n_fail++;
        $display("FAIL send_msg8 @%0t: got %h expected %h", $time, send_msg8, q8[0]);
      end
    end
    if (rst) q8.delete();
    else if (q8.size() != 0) begin
      if (sr) void'(q8.pop_front());
    end else if (rv) begin
      for (int i = 0; i < N8; i++) q8.push_back(msg[i*W8 +: W8]);
    end
    @(negedge clk);
  endtask

  task automatic cycle1(input logic rst, input logic rv, input logic [W1-1:0] msg,
                        input logic sr);
    logic exp_rdy;
    logic exp_val;
    reset1    = rst;
    recv_val1 = rv;
    recv_msg1 = msg;
    send_rdy1 = sr;
    #1;
    exp_rdy = !rst && (q1.size() == 0);
    exp_val = !rst && (q1.size() != 0);
    if (send_val1 && send_rdy1) beats1++;
    if (recv_val1 && recv_rdy1) hs1++;
    n_tests++;
    if (recv_rdy1 !== exp_rdy) begin
      n_fail++;
      $display("FAIL recv_rdy1 @%0t: got %b expected %b", $time, recv_rdy1, exp_rdy);
    end
    n_tests++;
    if (send_val1 !== exp_val) begin
      n_fail++;
      $display("FAIL send_val1 @%0t: got %b expected %b", $time, send_val1, exp_val);
    end
    if (exp_val) begin
      n_tests++;
      if (send_msg1 !== q1[0]) begin
        n_fail++;
        $display("FAIL send_msg1 @%0t: got %h expected %h", $time, send_msg1, q1[0]);
      end
    end
    if (rst) q1.delete();
    else if (q1.size() != 0) begin
      if (sr) void'(q1.pop_front());
    end else if (rv) begin
      q1.push_back(msg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle8(1'b1, 1'b1, rand_blk8(), 1'b1);
    cycle8(1'b1, 1'b0, rand_blk8(), 1'b0);
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b0);
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
  endtask

  task automatic test_single();
    logic [N8*W8-1:0] blk;
    for (int i = 0; i < N8; i++) blk[i*W8 +: W8] = 32'h11 * (i + 1);
    cycle8(1'b0, 1'b1, blk, 1'b1);
    for (int i = 0; i < N8; i++) cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    logic sr;
    cycle8(1'b0, 1'b1, rand_blk8(), 1'b1);
    for (int c = 0; c < 30 && q8.size() != 0; c++) begin
      sr = 1'b1;
      if (q8.size() == N8 - 2 && stalls < 3) begin
        sr = 1'b0;
        stalls++;
      end
      cycle8(1'b0, 1'b0, rand_blk8(), sr);
    end
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
  endtask

  task automatic test_recv_in_send();
    logic [N8*W8-1:0] blk_b;
    blk_b = rand_blk8();
    cycle8(1'b0, 1'b1, rand_blk8(), 1'b1);
    for (int c = 0; c < N8 + 1; c++) cycle8(1'b0, 1'b1, blk_b, 1'b1);
    for (int c = 0; c < 20 && q8.size() != 0; c++) cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle8(1'b0, 1'b1, rand_blk8(), 1'b1);
    for (int c = 0; c < 5; c++) cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
    cycle8(1'b1, 1'b0, rand_blk8(), 1'b1);
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
    cycle8(1'b0, 1'b1, rand_blk8(), 1'b1);
    for (int c = 0; c < 40 && q8.size() != 0; c++)
      cycle8(1'b0, 1'b0, rand_blk8(), 1'($urandom_range(0, 1)));
    cycle8(1'b0, 1'b0, rand_blk8(), 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++)
      cycle8(1'b0, 1'($urandom_range(0, 1)), rand_blk8(), 1'($urandom_range(0, 3) != 0));
  endtask

  task automatic test_n1();
    int b0;
    int h0;
    cycle1(1'b1, 1'b0, 16'h0, 1'b0);
    cycle1(1'b0, 1'b0, 16'h0, 1'b1);
    cycle1(1'b0, 1'b1, 16'hBEEF, 1'b1);
    cycle1(1'b0, 1'b0, 16'h1234, 1'b1);
    cycle1(1'b0, 1'b0, 16'h5678, 1'b1);
    b0 = beats1;
    h0 = hs1;
    for (int c = 0; c < 4; c++) cycle1(1'b0, 1'b1, 16'($urandom), 1'b1);
    n_tests++;
    if (beats1 - b0 !== 2) begin
      n_fail++;
      $display("FAIL n1_throughput_beats: got %0d expected 2", beats1 - b0);
    end
    n_tests++;
    if (hs1 - h0 !== 2) begin
      n_fail++;
      $display("FAIL n1_throughput_blocks: got %0d expected 2", hs1 - h0);
    end
    for (int c = 0; c < 40; c++)
      cycle1(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_recv_in_send();
    test_reset_mid();
    test_random();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
